// File: rtl/sdr_arb_pkg.sv
// sdr_arb_pkg: shared types, widths and helpers for the SDRAM toggle arbiters
package sdr_arb_pkg;
  typedef enum logic {ST_IDLE, ST_ISSUE} arb_state_t;
  localparam int SDR_DATA_W = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sdr_toggle_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker, first pending client after last_grant wins
module rr_grant #(
  parameter int NUM_CLIENTS = 4,
  parameter int IW = sdr_arb_pkg::idx_w(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] pending,
  input  logic [IW-1:0]          last_grant,
  output logic [IW-1:0]          grant,
  output logic                   grant_valid
);
  logic [IW-1:0] c;
  always_comb begin
    grant = '0;
    c = '0;
    grant_valid = |pending;
    // Scan farthest-first so the nearest pending client after last_grant overwrites the rest
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      c = IW'((int'(last_grant) + k) % NUM_CLIENTS);
      if (pending[c]) grant = c;
    end
  end
endmodule

// File: rtl/sdr_toggle_arbiter.sv
// sdr_toggle_arbiter: round-robin arbiter from toggle-handshake ROM clients to one SDRAM read port
module sdr_toggle_arbiter
  import sdr_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W = 27
) (
  input  logic                              clk,
  input  logic                              RESn,
  input  logic [NUM_CLIENTS-1:0]            cl_req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]     cl_addr,
  output logic [NUM_CLIENTS-1:0]            cl_ack,
  output logic [NUM_CLIENTS*SDR_DATA_W-1:0] cl_data,
  output logic                              ctrl_req,
  output logic [ADDR_W-1:0]                 ctrl_addr,
  input  logic                              ctrl_ack,
  input  logic [SDR_DATA_W-1:0]             ctrl_q,
  output logic                              busy
);
  localparam int IW = idx_w(NUM_CLIENTS);
  arb_state_t state;
  logic [IW-1:0] last_grant, cur, grant;
  logic grant_valid;
  logic [ADDR_W-1:0] sel_addr;
  assign sel_addr = cl_addr[int'(grant)*ADDR_W +: ADDR_W];
  rr_grant #(.NUM_CLIENTS(NUM_CLIENTS), .IW(IW)) u_rr (
    .pending(cl_req ^ cl_ack),
    .last_grant(last_grant),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  // A stray ctrl_ack while idle (e.g. left over from before reset) is dropped
  always_ff @(posedge clk or negedge RESn) begin
    if (!RESn) begin
      state      <= ST_IDLE;
      ctrl_req   <= 1'b0;
      ctrl_addr  <= '0;
      cl_ack     <= '0;
      cl_data    <= '0;
      busy       <= 1'b0;
      last_grant <= IW'(NUM_CLIENTS - 1);
      cur        <= '0;
    end else if (state == ST_IDLE) begin
      if (grant_valid) begin
        state      <= ST_ISSUE;
        cur        <= grant;
        last_grant <= grant;
        ctrl_addr  <= sel_addr & ~ADDR_W'(1);
        ctrl_req   <= 1'b1;
        busy       <= 1'b1;
      end
    end else if (ctrl_ack) begin
      cl_data[int'(cur)*SDR_DATA_W +: SDR_DATA_W] <= ctrl_q;
      cl_ack[cur] <= ~cl_ack[cur];
      ctrl_req    <= 1'b0;
      busy        <= 1'b0;
      state       <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_sdr_toggle_arbiter.sv
// tb_sdr_toggle_arbiter: directed-vector bench for sdr_toggle_arbiter with a hand-driven controller
module tb_sdr_toggle_arbiter;
  localparam int N = 4;
  localparam int AW = 27;
  logic clk = 0;
  logic RESn = 0;
  logic [N-1:0] cl_req = '0;
  logic [N*AW-1:0] cl_addr = '0;
  logic [N-1:0] cl_ack;
  logic [N*16-1:0] cl_data;
  logic ctrl_req;
  logic [AW-1:0] ctrl_addr;
  logic ctrl_ack = 0;
  logic [15:0] ctrl_q = '0;
  logic busy;
  int nvec = 0;
  int nerr = 0;
  logic [AW-1:0] a [N];
  logic [15:0] exp_d [N];

  sdr_toggle_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW)) dut (
    .clk(clk), .RESn(RESn), .cl_req(cl_req), .cl_addr(cl_addr), .cl_ack(cl_ack),
    .cl_data(cl_data), .ctrl_req(ctrl_req), .ctrl_addr(ctrl_addr), .ctrl_ack(ctrl_ack),
    .ctrl_q(ctrl_q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESn = 0;
    cl_req = '0;
    ctrl_ack = 0;
    for (int i = 0; i < N; i++) exp_d[i] = '0;
    step();
    RESn = 1;
    step();
  endtask

  task automatic test_reset();
    RESn = 0;
    step();
    nvec++; if (ctrl_req !== 1'b0) begin nerr++; $display("FAIL reset_ctrl_req got %b want 0", ctrl_req); end
    nvec++; if (ctrl_addr !== '0) begin nerr++; $display("FAIL reset_ctrl_addr got %h want 0", ctrl_addr); end
    nvec++; if (cl_ack !== '0) begin nerr++; $display("FAIL reset_cl_ack got %b want 0", cl_ack); end
    nvec++; if (cl_data !== '0) begin nerr++; $display("FAIL reset_cl_data got %h want 0", cl_data); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    RESn = 1;
    step();
  endtask

  task automatic test_single();
    cl_addr[0 +: AW] = 27'h0123457;
    cl_req[0] = ~cl_req[0];
    nvec++; if (ctrl_req !== 1'b0) begin nerr++; $display("FAIL single_req_early got %b want 0", ctrl_req); end
    step();
    nvec++; if (ctrl_req !== 1'b1) begin nerr++; $display("FAIL single_req_rise got %b want 1", ctrl_req); end
    nvec++; if (ctrl_addr !== 27'h0123456) begin nerr++; $display("FAIL single_addr got %h want 0123456", ctrl_addr); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy got %b want 1", busy); end
    step();
    ctrl_ack = 1; ctrl_q = 16'hBEEF;
    nvec++; if (cl_ack !== 4'b0000) begin nerr++; $display("FAIL single_ack_early got %b want 0000", cl_ack); end
    step();
    ctrl_ack = 0;
    nvec++; if (cl_data[0 +: 16] !== 16'hBEEF) begin nerr++; $display("FAIL single_data got %h want beef", cl_data[0 +: 16]); end
    nvec++; if (cl_ack !== 4'b0001) begin nerr++; $display("FAIL single_ack got %b want 0001", cl_ack); end
    nvec++; if (ctrl_req !== 1'b0) begin nerr++; $display("FAIL single_req_drop got %b want 0", ctrl_req); end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(((i + 1) << 8) | 1);
      cl_addr[i*AW +: AW] = a[i];
    end
    cl_req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      step();
      nvec++; if (ctrl_req !== 1'b1) begin nerr++; $display("FAIL all4_req[%0d] got %b want 1", i, ctrl_req); end
      nvec++; if (ctrl_addr !== (a[i] & ~AW'(1))) begin nerr++; $display("FAIL all4_addr[%0d] got %h want %h", i, ctrl_addr, a[i] & ~AW'(1)); end
      ctrl_ack = 1; ctrl_q = 16'hA000 + 16'(i);
      exp_d[i] = ctrl_q;
      step();
      ctrl_ack = 0;
      nvec++; if (ctrl_req !== 1'b0) begin nerr++; $display("FAIL all4_gap[%0d] got %b want 0", i, ctrl_req); end
      nvec++; if (cl_ack[i] !== 1'b1) begin nerr++; $display("FAIL all4_ack[%0d] got %b want 1", i, cl_ack[i]); end
      nvec++; if (cl_data[i*16 +: 16] !== exp_d[i]) begin nerr++; $display("FAIL all4_data[%0d] got %h want %h", i, cl_data[i*16 +: 16], exp_d[i]); end
    end
  endtask

  task automatic test_wrap();
    cl_req[2] = ~cl_req[2];
    step();
    nvec++; if (ctrl_addr !== (a[2] & ~AW'(1))) begin nerr++; $display("FAIL wrap_c2_addr got %h want %h", ctrl_addr, a[2] & ~AW'(1)); end
    ctrl_ack = 1; ctrl_q = 16'h2222; exp_d[2] = 16'h2222;
    step();
    ctrl_ack = 0;
    cl_req[1] = ~cl_req[1];
    cl_req[3] = ~cl_req[3];
    step();
    nvec++; if (ctrl_addr !== (a[3] & ~AW'(1))) begin nerr++; $display("FAIL wrap_first got %h want %h (client 3)", ctrl_addr, a[3] & ~AW'(1)); end
    ctrl_ack = 1; ctrl_q = 16'h3333; exp_d[3] = 16'h3333;
    step();
    ctrl_ack = 0;
    step();
    nvec++; if (ctrl_addr !== (a[1] & ~AW'(1))) begin nerr++; $display("FAIL wrap_second got %h want %h (client 1)", ctrl_addr, a[1] & ~AW'(1)); end
    ctrl_ack = 1; ctrl_q = 16'h1111; exp_d[1] = 16'h1111;
    step();
    ctrl_ack = 0;
    nvec++; if (cl_ack !== cl_req) begin nerr++; $display("FAIL wrap_acks got %b want %b", cl_ack, cl_req); end
    for (int i = 0; i < N; i++) begin
      nvec++; if (cl_data[i*16 +: 16] !== exp_d[i]) begin nerr++; $display("FAIL wrap_data[%0d] got %h want %h", i, cl_data[i*16 +: 16], exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    cl_req[0] = ~cl_req[0];
    step();
    nvec++; if (ctrl_addr !== (a[0] & ~AW'(1))) begin nerr++; $display("FAIL b2b_c0_addr got %h want %h", ctrl_addr, a[0] & ~AW'(1)); end
    cl_req[1] = ~cl_req[1];
    step();
    step();
    nvec++; if (ctrl_req !== 1'b1 || ctrl_addr !== (a[0] & ~AW'(1))) begin nerr++; $display("FAIL b2b_hold got req %b addr %h want 1 %h", ctrl_req, ctrl_addr, a[0] & ~AW'(1)); end
    ctrl_ack = 1; ctrl_q = 16'h1234; exp_d[0] = 16'h1234;
    step();
    ctrl_ack = 0;
    nvec++; if (cl_data[0 +: 16] !== 16'h1234) begin nerr++; $display("FAIL b2b_c0_data got %h want 1234", cl_data[0 +: 16]); end
    nvec++; if (cl_data[16 +: 16] !== exp_d[1]) begin nerr++; $display("FAIL b2b_c1_early got %h want %h", cl_data[16 +: 16], exp_d[1]); end
    nvec++; if (ctrl_req !== 1'b0) begin nerr++; $display("FAIL b2b_gap got %b want 0", ctrl_req); end
    step();
    nvec++; if (ctrl_req !== 1'b1 || ctrl_addr !== (a[1] & ~AW'(1))) begin nerr++; $display("FAIL b2b_c1_grant got req %b addr %h want 1 %h", ctrl_req, ctrl_addr, a[1] & ~AW'(1)); end
    ctrl_ack = 1; ctrl_q = 16'h5678; exp_d[1] = 16'h5678;
    step();
    ctrl_ack = 0;
    nvec++; if (cl_data[16 +: 16] !== 16'h5678) begin nerr++; $display("FAIL b2b_c1_data got %h want 5678", cl_data[16 +: 16]); end
    nvec++; if (cl_data[0 +: 16] !== 16'h1234) begin nerr++; $display("FAIL b2b_c0_keep got %h want 1234", cl_data[0 +: 16]); end
    nvec++; if (cl_ack !== cl_req) begin nerr++; $display("FAIL b2b_acks got %b want %b", cl_ack, cl_req); end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    cl_addr[2*AW +: AW] = 27'h0000777;
    cl_req[2] = 1'b1;
    step();
    nvec++; if (ctrl_req !== 1'b1) begin nerr++; $display("FAIL rst_issue_req got %b want 1", ctrl_req); end
    #2;
    RESn = 0;
    #1;
    nvec++; if (ctrl_req !== 1'b0) begin nerr++; $display("FAIL rst_async_drop got %b want 0", ctrl_req); end
    cl_req = '0;
    step();
    RESn = 1;
    ctrl_ack = 1; ctrl_q = 16'hFFFF;
    step();
    ctrl_ack = 0;
    step();
    nvec++; if (cl_ack !== '0) begin nerr++; $display("FAIL rst_stale_ack got %b want 0000", cl_ack); end
    nvec++; if (cl_data !== '0) begin nerr++; $display("FAIL rst_stale_data got %h want 0", cl_data); end
    nvec++; if (ctrl_req !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rst_stale_idle got req %b busy %b want 0 0", ctrl_req, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_back_to_back();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
